// File: rtl/bk_pkg.sv
// Shared types and helpers for the Brent-Kung prefix adder.
// Holds the (g,p) pair type, the tree depth helper and the prefix combine operator.
package bk_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of up-sweep levels for a power-of-two operand width.
    function automatic int levels(input int width);
        return $clog2(width);
    endfunction

    // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant span.
    function automatic gp_t bk_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// Black cell of the prefix tree: merges a higher (g,p) span with the adjacent lower span.
module bk_gp_cell
    import bk_pkg::*;
(
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    gp_t hi;
    gp_t lo;
    gp_t res;

    assign hi    = '{g: g_hi, p: p_hi};
    assign lo    = '{g: g_lo, p: p_lo};
    assign res   = bk_combine(hi, lo);
    assign g_out = res.g;
    assign p_out = res.p;

endmodule

// File: rtl/brent_kung_adder.sv
// Registered WIDTH-bit adder (sum = a + b + cin, carry-out in the MSB) built on a
// structural Brent-Kung carry network. Valid semantics: a/b/cin are sampled on a rising
// edge only when in_valid=1; out_valid=1 marks sum as that result one cycle later; no backpressure.
module brent_kung_adder
    import bk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH:0]   sum
);

    localparam int L      = levels(WIDTH);
    localparam int STAGES = 2 * L;

    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH:0]   sum_next;
    gp_t              node0_raw;
    gp_t              cin_node;
    gp_t              node0;

    // Stage 0 holds bit-level (g,p); stage STAGES-1 holds G[i:0] for every i.
    logic [WIDTH-1:0] gs [STAGES];
    logic [WIDTH-1:0] ps [STAGES];

    assign p = a ^ b;

    // cin is G[-1]: folding it into bit 0 makes every prefix G[i:0] include it.
    assign node0_raw = '{g: a[0] & b[0], p: p[0]};
    assign cin_node  = '{g: cin, p: 1'b0};
    assign node0     = bk_combine(node0_raw, cin_node);

    assign gs[0] = {a[WIDTH-1:1] & b[WIDTH-1:1], node0.g};
    assign ps[0] = {p[WIDTH-1:1], node0.p};

    for (genvar k = 0; k < L; k++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i + 1) % (2 ** (k + 1))) == 0) begin : g_cell
                bk_gp_cell u_cell (
                    .g_hi  (gs[k][i]),
                    .p_hi  (ps[k][i]),
                    .g_lo  (gs[k][i-2**k]),
                    .p_lo  (ps[k][i-2**k]),
                    .g_out (gs[k+1][i]),
                    .p_out (ps[k+1][i])
                );
            end else begin : g_pass
                assign gs[k+1][i] = gs[k][i];
                assign ps[k+1][i] = ps[k][i];
            end
        end
    end

    // Down-sweep runs from the widest span back to span 1, filling the odd positions.
    for (genvar j = 0; j < L - 1; j++) begin : g_down
        localparam int D = L - 2 - j;
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if ((((i + 1) % (2 ** (D + 1))) == (2 ** D)) && (i >= 3 * (2 ** D) - 1)) begin : g_cell
                bk_gp_cell u_cell (
                    .g_hi  (gs[L+j][i]),
                    .p_hi  (ps[L+j][i]),
                    .g_lo  (gs[L+j][i-2**D]),
                    .p_lo  (ps[L+j][i-2**D]),
                    .g_out (gs[L+j+1][i]),
                    .p_out (ps[L+j+1][i])
                );
            end else begin : g_pass
                assign gs[L+j+1][i] = gs[L+j][i];
                assign ps[L+j+1][i] = ps[L+j][i];
            end
        end
    end

    // Group propagate of the final stage has no consumer.
    logic unused_final_p;
    assign unused_final_p = ^ps[STAGES-1];

    assign c        = {gs[STAGES-1], cin};
    assign sum_next = {c[WIDTH], p ^ c[WIDTH-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                sum <= sum_next;
            end
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_brent_kung_adder.sv
// Directed bench for brent_kung_adder: exhaustive 4-bit sweep plus 8/16-bit corners and random vectors.
module tb_brent_kung_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        ov4, ov8, ov16;
    logic [4:0]  sum4;
    logic [8:0]  sum8;
    logic [16:0] sum16;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    brent_kung_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin),
        .out_valid(ov4), .sum(sum4)
    );

    brent_kung_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
        .out_valid(ov8), .sum(sum8)
    );

    brent_kung_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .cin(cin),
        .out_valid(ov16), .sum(sum16)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] aa, input logic [3:0] bb, input logic c, input logic v);
        a4       = aa;
        b4       = bb;
        cin      = c;
        in_valid = v;
    endtask

    task automatic drive_wide(input logic [7:0] aa8, input logic [7:0] bb8,
                              input logic [15:0] aa16, input logic [15:0] bb16, input logic c);
        a8       = aa8;
        b8       = bb8;
        a16      = aa16;
        b16      = bb16;
        cin      = c;
        in_valid = 1'b1;
    endtask

    initial begin
        logic [4:0]  e4;
        logic [8:0]  e8;
        logic [16:0] e16;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        cin      = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;

        #1;
        chk("reset_sum4", 64'(sum4), 64'd0);
        chk("reset_ov4", 64'(ov4), 64'd0);
        chk("reset_sum16", 64'(sum16), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // exhaustive 4-bit sweep over {cin,b,a}
        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            drive4(vv[3:0], vv[7:4], vv[8], 1'b1);
            e4 = 5'(vv[3:0]) + 5'(vv[7:4]) + 5'(vv[8]);
            exp_q.push_back(64'(e4));
            step();
            chk("exh_sum4", 64'(sum4), exp_q.pop_front());
            chk("exh_ov4", 64'(ov4), 64'd1);
        end

        drive4(4'hF, 4'hF, 1'b1, 1'b1);
        step();
        chk("max_sum4", 64'(sum4), 64'd31);

        drive4(4'h0, 4'h0, 1'b0, 1'b1);
        step();
        chk("zero_sum4", 64'(sum4), 64'd0);

        drive4(4'hF, 4'h0, 1'b1, 1'b1);
        step();
        chk("ripple_sum4", 64'(sum4), 64'h10);

        // valid gating and hold
        drive4(4'd3, 4'd4, 1'b0, 1'b1);
        step();
        chk("gate_sum_a", 64'(sum4), 64'd7);
        chk("gate_ov_a", 64'(ov4), 64'd1);
        drive4(4'd9, 4'd4, 1'b0, 1'b0);
        step();
        chk("gate_sum_b", 64'(sum4), 64'd7);
        chk("gate_ov_b", 64'(ov4), 64'd0);
        drive4(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        step();
        chk("x_hold_sum", 64'(sum4), 64'd7);
        chk("x_hold_ov", 64'(ov4), 64'd0);

        // asynchronous reset mid-stream
        drive4(4'd5, 4'd6, 1'b0, 1'b1);
        step();
        chk("pre_rst_sum", 64'(sum4), 64'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sum", 64'(sum4), 64'd0);
        chk("async_rst_ov", 64'(ov4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_hold_sum", 64'(sum4), 64'd0);
        step();
        chk("post_rst_sum", 64'(sum4), 64'd11);
        chk("post_rst_ov", 64'(ov4), 64'd1);

        // wide corners
        drive_wide(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b1);
        step();
        chk("max_sum8", 64'(sum8), 64'd511);
        chk("max_sum16", 64'(sum16), 64'd131071);
        drive_wide(8'hAA, 8'h55, 16'hAAAA, 16'h5555, 1'b1);
        step();
        chk("alt_sum8", 64'(sum8), 64'd256);
        chk("alt_sum16", 64'(sum16), 64'd65536);
        chk("alt_ov16", 64'(ov16), 64'd1);
        drive_wide(8'h80, 8'h80, 16'h8000, 16'h8000, 1'b0);
        step();
        chk("msb_sum8", 64'(sum8), 64'h100);
        chk("msb_sum16", 64'(sum16), 64'h10000);

        // random wide vectors against the reference a+b+cin
        for (int n = 0; n < 400; n++) begin
            drive_wide(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       1'($urandom_range(0, 1)));
            e8  = 9'(a8) + 9'(b8) + 9'(cin);
            e16 = 17'(a16) + 17'(b16) + 17'(cin);
            step();
            chk("rand_sum8", 64'(sum8), 64'(e8));
            chk("rand_sum16", 64'(sum16), 64'(e16));
            chk("rand_ov8", 64'(ov8), 64'd1);
        end

        in_valid = 1'b0;
        step();
        chk("idle_ov16", 64'(ov16), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
